// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcode/Func
// constants, instruction classes and the datapath select codes.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // Bit positions in the one-hot instruction class vector
  typedef enum logic [3:0] {
    IC_ADDU = 4'd0,
    IC_SUBU = 4'd1,
    IC_ORI  = 4'd2,
    IC_LW   = 4'd3,
    IC_SW   = 4'd4,
    IC_BEQ  = 4'd5,
    IC_LUI  = 4'd6,
    IC_J    = 4'd7,
    IC_JAL  = 4'd8,
    IC_JR   = 4'd9
  } iclass_e;

  localparam int NUM_IC = 10;

  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_LUI = 4'b1000;

  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_RS     = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  function automatic logic [3:0] alu_op_for(input logic [NUM_IC-1:0] cls);
    logic [3:0] op;
    op = 4'b0000;
    if (cls[IC_ADDU] | cls[IC_LW] | cls[IC_SW]) op = ALU_ADD;
    if (cls[IC_SUBU] | cls[IC_BEQ])             op = ALU_SUB;
    if (cls[IC_ORI])                            op = ALU_OR;
    if (cls[IC_LUI])                            op = ALU_LUI;
    return op;
  endfunction

endpackage

// File: rtl/mc_ctrl_instr_dec.sv
// Maps the IR opcode and function fields to a one-hot instruction class;
// an all-zero vector means the encoding is not supported.
module instr_dec
  import mc_pkg::*;
(
  input  logic [5:0]        Op,
  input  logic [5:0]        Func,
  output logic [NUM_IC-1:0] cls
);

  always_comb begin
    cls = '0;
    case (Op)
      OP_RTYPE: begin
        case (Func)
          FN_ADDU: cls[IC_ADDU] = 1'b1;
          FN_SUBU: cls[IC_SUBU] = 1'b1;
          FN_JR:   cls[IC_JR]   = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:  cls[IC_ORI] = 1'b1;
      OP_LW:   cls[IC_LW]  = 1'b1;
      OP_SW:   cls[IC_SW]  = 1'b1;
      OP_BEQ:  cls[IC_BEQ] = 1'b1;
      OP_LUI:  cls[IC_LUI] = 1'b1;
      OP_J:    cls[IC_J]   = 1'b1;
      OP_JAL:  cls[IC_JAL] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing
// with handshaked instruction and data memories.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Func,
  input  logic       Zero,
  input  logic       im_rdy,
  input  logic       dm_rdy,
  output logic       im_req,
  output logic       dm_req,
  output logic       dm_we,
  output logic       IRWr,
  output logic       PCWr,
  output logic [1:0] NPCSel,
  output logic       RegWr,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic [3:0] ALUOp,
  output logic       ALUSrc,
  output logic       EXTOp,
  output logic       instr_done,
  output logic       illegal
);

  state_t            state;
  logic [NUM_IC-1:0] cls;
  logic              is_jump, to_exec, is_mem, to_wb;

  instr_dec u_dec (
    .Op   (Op),
    .Func (Func),
    .cls  (cls)
  );

  assign is_jump = cls[IC_J] | cls[IC_JAL] | cls[IC_JR];
  assign is_mem  = cls[IC_LW] | cls[IC_SW];
  assign to_wb   = cls[IC_ADDU] | cls[IC_SUBU] | cls[IC_ORI] | cls[IC_LUI];
  assign to_exec = to_wb | is_mem | cls[IC_BEQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FETCH;
    end else begin
      case (state)
        ST_FETCH:  if (im_rdy) state <= ST_DECODE;
        ST_DECODE: state <= to_exec ? ST_EXEC : ST_FETCH;
        ST_EXEC: begin
          if (is_mem)     state <= ST_MEM;
          else if (to_wb) state <= ST_WB;
          else            state <= ST_FETCH;
        end
        ST_MEM: begin
          if (dm_rdy) state <= cls[IC_LW] ? ST_WB : ST_FETCH;
        end
        ST_WB:   state <= ST_FETCH;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Outputs are gated by rst_n so requests and write strobes vanish the
  // moment reset asserts, not at the next edge.
  always_comb begin
    im_req     = 1'b0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    IRWr       = 1'b0;
    PCWr       = 1'b0;
    NPCSel     = NPC_PC4;
    RegWr      = 1'b0;
    RegDst     = RD_RT;
    WDSel      = WD_ALU;
    ALUOp      = 4'b0000;
    ALUSrc     = 1'b0;
    EXTOp      = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      case (state)
        ST_FETCH: begin
          im_req = 1'b1;
          if (im_rdy) begin
            IRWr   = 1'b1;
            PCWr   = 1'b1;
            NPCSel = NPC_PC4;
          end
        end
        ST_DECODE: begin
          if (is_jump) begin
            PCWr       = 1'b1;
            NPCSel     = cls[IC_JR] ? NPC_RS : NPC_JUMP;
            instr_done = 1'b1;
            if (cls[IC_JAL]) begin
              RegWr  = 1'b1;
              RegDst = RD_RA;
              WDSel  = WD_PC4;
            end
          end else if (!to_exec) begin
            illegal = 1'b1;
          end
        end
        ST_EXEC: begin
          ALUOp  = alu_op_for(cls);
          ALUSrc = cls[IC_ORI] | cls[IC_LW] | cls[IC_SW] | cls[IC_LUI];
          EXTOp  = cls[IC_LW] | cls[IC_SW] | cls[IC_BEQ];
          if (cls[IC_BEQ]) begin
            PCWr       = Zero;
            NPCSel     = NPC_BRANCH;
            instr_done = 1'b1;
          end
        end
        ST_MEM: begin
          dm_req = 1'b1;
          dm_we  = cls[IC_SW];
          if (dm_rdy && cls[IC_SW]) instr_done = 1'b1;
        end
        ST_WB: begin
          RegWr      = 1'b1;
          instr_done = 1'b1;
          RegDst     = (cls[IC_ADDU] | cls[IC_SUBU]) ? RD_RD : RD_RT;
          WDSel      = cls[IC_LW] ? WD_MEM : WD_ALU;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction cycle traces built from the
// instruction rules, driven with random wait states and compared every cycle.
module tb_mc_ctrl;

  localparam int K_ADDU = 0;
  localparam int K_SUBU = 1;
  localparam int K_ORI  = 2;
  localparam int K_LW   = 3;
  localparam int K_SW   = 4;
  localparam int K_BEQ  = 5;
  localparam int K_LUI  = 6;
  localparam int K_J    = 7;
  localparam int K_JAL  = 8;
  localparam int K_JR   = 9;
  localparam int K_ILL  = 10;

  typedef struct packed {
    logic       im_req;
    logic       dm_req;
    logic       dm_we;
    logic       irwr;
    logic       pcwr;
    logic [1:0] npcsel;
    logic       regwr;
    logic [1:0] regdst;
    logic [1:0] wdsel;
    logic [3:0] aluop;
    logic       alusrc;
    logic       extop;
    logic       done;
    logic       illegal;
  } out_t;

  typedef struct packed {
    logic       im_rdy;
    logic       dm_rdy;
    logic       zero;
    logic [5:0] op;
    logic [5:0] func;
    out_t       exp;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Op, Func;
  logic       Zero, im_rdy, dm_rdy;
  logic       im_req, dm_req, dm_we, IRWr, PCWr, RegWr, ALUSrc, EXTOp, instr_done, illegal;
  logic [1:0] NPCSel, RegDst, WDSel;
  logic [3:0] ALUOp;
  out_t       dutOut;

  int   assertCount = 0;
  int   failCount   = 0;
  int   lastLat, lastDmReq, lastIll;
  cyc_t trace[$];

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Op         (Op),
    .Func       (Func),
    .Zero       (Zero),
    .im_rdy     (im_rdy),
    .dm_rdy     (dm_rdy),
    .im_req     (im_req),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .IRWr       (IRWr),
    .PCWr       (PCWr),
    .NPCSel     (NPCSel),
    .RegWr      (RegWr),
    .RegDst     (RegDst),
    .WDSel      (WDSel),
    .ALUOp      (ALUOp),
    .ALUSrc     (ALUSrc),
    .EXTOp      (EXTOp),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  assign dutOut = {im_req, dm_req, dm_we, IRWr, PCWr, NPCSel, RegWr, RegDst, WDSel,
                   ALUOp, ALUSrc, EXTOp, instr_done, illegal};

  task automatic checkOutput(input string name, input out_t act, input out_t exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    assertCount++;
    if (act != exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int classify(input logic [5:0] op, input logic [5:0] func);
    case (op)
      6'b000000: begin
        if (func == 6'b100001) return K_ADDU;
        if (func == 6'b100011) return K_SUBU;
        if (func == 6'b001000) return K_JR;
        return K_ILL;
      end
      6'b001101: return K_ORI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b001111: return K_LUI;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      default:   return K_ILL;
    endcase
  endfunction

  task automatic encode(input int k, output logic [5:0] op, output logic [5:0] func);
    func = 6'($urandom);
    case (k)
      K_ADDU: begin op = 6'b000000; func = 6'b100001; end
      K_SUBU: begin op = 6'b000000; func = 6'b100011; end
      K_JR:   begin op = 6'b000000; func = 6'b001000; end
      K_ORI:  op = 6'b001101;
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      K_BEQ:  op = 6'b000100;
      K_LUI:  op = 6'b001111;
      K_J:    op = 6'b000010;
      K_JAL:  op = 6'b000011;
      default: begin
        op = 6'($urandom);
        while (classify(op, func) != K_ILL) begin
          op   = 6'($urandom);
          func = 6'($urandom);
        end
      end
    endcase
  endtask

  function automatic cyc_t noise();
    cyc_t c;
    c        = '0;
    c.op     = 6'($urandom);
    c.func   = 6'($urandom);
    c.zero   = 1'($urandom);
    c.im_rdy = 1'($urandom);
    c.dm_rdy = 1'($urandom);
    return c;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, phase by phase
  task automatic buildInstr(input int k, input logic [5:0] op, input logic [5:0] func,
                            input logic zero, input int imw, input int dmw);
    cyc_t c;
    for (int i = 0; i <= imw; i++) begin
      c            = noise();
      c.im_rdy     = (i == imw);
      c.exp.im_req = 1'b1;
      if (i == imw) begin
        c.exp.irwr = 1'b1;
        c.exp.pcwr = 1'b1;
      end
      trace.push_back(c);
    end
    c      = noise();
    c.op   = op;
    c.func = func;
    case (k)
      K_J:   begin c.exp.pcwr = 1; c.exp.npcsel = 2'b10; c.exp.done = 1; end
      K_JR:  begin c.exp.pcwr = 1; c.exp.npcsel = 2'b11; c.exp.done = 1; end
      K_JAL: begin
        c.exp.pcwr = 1; c.exp.npcsel = 2'b10; c.exp.regwr = 1;
        c.exp.regdst = 2'b10; c.exp.wdsel = 2'b10; c.exp.done = 1;
      end
      K_ILL: c.exp.illegal = 1'b1;
      default: ;
    endcase
    trace.push_back(c);
    if (k == K_J || k == K_JR || k == K_JAL || k == K_ILL) return;
    c      = noise();
    c.op   = op;
    c.func = func;
    if (k == K_BEQ) c.zero = zero;
    case (k)
      K_ADDU, K_LW, K_SW: c.exp.aluop = 4'b0001;
      K_SUBU, K_BEQ:      c.exp.aluop = 4'b0010;
      K_ORI:              c.exp.aluop = 4'b0100;
      default:            c.exp.aluop = 4'b1000;
    endcase
    c.exp.alusrc = (k == K_ORI || k == K_LW || k == K_SW || k == K_LUI);
    c.exp.extop  = (k == K_LW || k == K_SW || k == K_BEQ);
    if (k == K_BEQ) begin
      c.exp.pcwr   = zero;
      c.exp.npcsel = 2'b01;
      c.exp.done   = 1'b1;
      trace.push_back(c);
      return;
    end
    trace.push_back(c);
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= dmw; i++) begin
        c            = noise();
        c.op         = op;
        c.func       = func;
        c.dm_rdy     = (i == dmw);
        c.exp.dm_req = 1'b1;
        c.exp.dm_we  = (k == K_SW);
        c.exp.done   = (k == K_SW) && (i == dmw);
        trace.push_back(c);
      end
      if (k == K_SW) return;
    end
    c            = noise();
    c.op         = op;
    c.func       = func;
    c.exp.regwr  = 1'b1;
    c.exp.done   = 1'b1;
    c.exp.regdst = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
    c.exp.wdsel  = (k == K_LW) ? 2'b01 : 2'b00;
    trace.push_back(c);
  endtask

  task automatic addInstr(input int k, input logic zero, input int imw, input int dmw);
    logic [5:0] op, func;
    encode(k, op, func);
    buildInstr(k, op, func, zero, imw, dmw);
  endtask

  // Drives up to maxCyc queued cycles (0 = all) and checks each one
  task automatic applyStimulus(input string tag, input int maxCyc);
    cyc_t c;
    int   n;
    n         = 0;
    lastLat   = 0;
    lastDmReq = 0;
    lastIll   = 0;
    while (trace.size() > 0 && (maxCyc == 0 || n < maxCyc)) begin
      c = trace.pop_front();
      n++;
      @(posedge clk);
      #1;
      Op     = c.op;
      Func   = c.func;
      Zero   = c.zero;
      im_rdy = c.im_rdy;
      dm_rdy = c.dm_rdy;
      @(negedge clk);
      checkOutput($sformatf("%s_c%0d", tag, n), dutOut, c.exp);
      if (dutOut.done && lastLat == 0) lastLat = n;
      if (dutOut.dm_req) lastDmReq++;
      if (dutOut.illegal) lastIll++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    out_t zeroOut, fetchOut;
    zeroOut         = '0;
    fetchOut        = '0;
    fetchOut.im_req = 1'b1;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      Op     = 6'($urandom);
      Func   = 6'($urandom);
      Zero   = 1'($urandom);
      im_rdy = 1'b1;
      dm_rdy = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("reset_c%0d", i), dutOut, zeroOut);
    end
    im_rdy = 1'b0;
    dm_rdy = 1'b0;
    #2 rst_n = 1'b1;
    #1 checkOutput("post_reset_im_req", dutOut, fetchOut);

    addInstr(K_ADDU, 1'b0, 0, 0);
    applyStimulus("addu", 0);
    checkValue("lat_addu", lastLat, 4);

    addInstr(K_LW, 1'b0, 0, 3);
    applyStimulus("lw_wait", 0);
    checkValue("lat_lw_wait", lastLat, 8);
    checkValue("lw_dm_req_cycles", lastDmReq, 4);

    addInstr(K_BEQ, 1'b1, 0, 0);
    applyStimulus("beq_taken", 0);
    checkValue("lat_beq_taken", lastLat, 3);

    addInstr(K_BEQ, 1'b0, 0, 0);
    applyStimulus("beq_not", 0);
    checkValue("lat_beq_not", lastLat, 3);

    addInstr(K_JAL, 1'b0, 0, 0);
    applyStimulus("jal", 0);
    checkValue("lat_jal", lastLat, 2);

    addInstr(K_SW, 1'b0, 2, 0);
    applyStimulus("sw_imwait", 0);
    checkValue("lat_sw_imwait", lastLat, 6);

    buildInstr(K_ILL, 6'b111111, 6'b000000, 1'b0, 0, 0);
    applyStimulus("illegal", 0);
    checkValue("illegal_pulses", lastIll, 1);
    checkValue("illegal_no_retire", lastLat, 0);

    // Reset arriving in the first MEM cycle of a store
    addInstr(K_SW, 1'b0, 0, 3);
    applyStimulus("sw_rst", 4);
    trace.delete();
    #2;
    rst_n  = 1'b0;
    im_rdy = 1'b0;
    dm_rdy = 1'b0;
    #1 checkOutput("rst_mid_mem_drop", dutOut, zeroOut);
    @(negedge clk);
    checkOutput("rst_mid_mem_hold", dutOut, zeroOut);
    #2 rst_n = 1'b1;
    #1 checkOutput("rst_release_im_req", dutOut, fetchOut);

    addInstr(K_ADDU, 1'b0, 0, 0);
    applyStimulus("addu_after_rst", 0);
    checkValue("lat_addu_after_rst", lastLat, 4);

    for (int i = 0; i < 80; i++) begin
      addInstr(int'($urandom_range(0, 10)), 1'($urandom), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)));
    end
    applyStimulus("rand", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port Op, input, 6 bits: IR[31:26], driven from the datapath IR register.
REQ-004 SHALL have port Func, input, 6 bits: IR[5:0].
REQ-005 SHALL have port Zero, input, 1 bit: ALU equality flag.
REQ-006 SHALL have port im_rdy, input, 1 bit: instruction memory data valid.
REQ-007 SHALL have port dm_rdy, input, 1 bit: data memory access complete.
REQ-008 SHALL have port im_req, output, 1 bit: instruction fetch request.
REQ-009 SHALL have port dm_req, output, 1 bit: data memory request.
REQ-010 SHALL have port dm_we, output, 1 bit: data memory write enable.
REQ-011 SHALL have port IRWr, output, 1 bit: IR load enable.
REQ-012 SHALL have port PCWr, output, 1 bit: PC write enable.
REQ-013 SHALL have port NPCSel, output, 2 bits: next-PC source; 00 = PC+4, 01 = branch, 10 = j/jal target, 11 = rs (jr).
REQ-014 SHALL have port RegWr, output, 1 bit: GPR write enable.
REQ-015 SHALL have port RegDst, output, 2 bits: write destination; 00 = rt, 01 = rd, 10 = $31.
REQ-016 SHALL have port WDSel, output, 2 bits: GPR write data; 00 = ALU result register, 01 = memory data register, 10 = PC+4.
REQ-017 SHALL have port ALUOp, output, 4 bits: one-hot; 0001 add, 0010 sub, 0100 or, 1000 lui.
REQ-018 SHALL have port ALUSrc, output, 1 bit: ALU B operand; 1 = extended immediate.
REQ-019 SHALL have port EXTOp, output, 1 bit: extender mode; 1 = sign extend.
REQ-020 SHALL have port instr_done, output, 1 bit: one-cycle pulse when an instruction retires.
REQ-021 SHALL have port illegal, output, 1 bit: one-cycle pulse when an unsupported opcode is decoded.

Function
REQ-022 SHALL implement states FETCH, DECODE, EXEC, MEM and WB.
REQ-023 FETCH SHALL assert im_req and hold that state until im_rdy = 1.
- In the im_rdy cycle: IRWr = 1, PCWr = 1, NPCSel = 00; next state DECODE.
REQ-024 DECODE SHALL classify addu, subu, ori, lw, sw, beq, lui, j, jal and jr.
- addu: Op 000000, Func 100001. subu: Op 000000, Func 100011. jr: Op 000000, Func 001000.
- ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011.
REQ-025 DECODE, j: PCWr = 1, NPCSel = 10, instr_done = 1; next state FETCH.
REQ-026 DECODE, jal: PCWr = 1, NPCSel = 10, RegWr = 1, RegDst = 10, WDSel = 10, instr_done = 1; next state FETCH.
REQ-027 DECODE, jr: PCWr = 1, NPCSel = 11, instr_done = 1; next state FETCH.
REQ-028 DECODE, any other encoding: illegal = 1, no write enables asserted; next state FETCH.
REQ-029 DECODE, remaining legal instructions: next state EXEC.
REQ-030 EXEC SHALL drive ALUOp per instruction:
- addu, lw, sw: add. subu, beq: sub. ori: or. lui: lui.
- ALUSrc = 1 for ori, lw, sw, lui. EXTOp = 1 for lw, sw, beq.
REQ-031 EXEC, beq: PCWr = Zero, NPCSel = 01, instr_done = 1; next state FETCH.
REQ-032 EXEC, lw or sw: next state MEM.
REQ-033 EXEC, any other instruction: next state WB.
REQ-034 MEM SHALL assert dm_req, with dm_we = 1 for sw only, and hold that state until dm_rdy = 1.
- sw: instr_done = 1 in the dm_rdy cycle; next state FETCH.
- lw: next state WB.
REQ-035 WB SHALL assert RegWr = 1, then return to FETCH with instr_done = 1.
- RegDst = 01 for addu/subu, 00 otherwise.
- WDSel = 01 for lw, 00 otherwise.
REQ-036 Every output not named for a state SHALL be 0 in that state.
- Outputs are combinational from the state register plus Op/Func/Zero.
REQ-037 Latency with zero-wait memories SHALL be:
- j, jal, jr: 2 cycles.
- beq: 3 cycles.
- addu, subu, ori, lui, sw: 4 cycles.
- lw: 5 cycles.
- Each wait cycle adds 1.
REQ-038 im_req and dm_req SHALL stay asserted continuously until the matching rdy signal is sampled high.
- rdy asserted while no request is pending SHALL be ignored.
REQ-039 Op and Func SHALL be treated as valid only from DECODE through the end of the instruction.

Reset
REQ-040 While rst_n = 0, the state SHALL be FETCH immediately (asynchronously) and all write enables, requests and pulses SHALL be 0.
REQ-041 Reset asserted during MEM or a FETCH wait SHALL drop the request in the same cycle, with no write and no retire.
REQ-042 After rst_n deasserts, im_req SHALL assert in the first cycle.

Structure
REQ-043 Package mc_pkg SHALL hold the state encoding, opcode and Func constants, and the ALUOp, NPCSel, RegDst and WDSel codes.
REQ-044 Sub-module instr_dec SHALL map Op/Func to a one-hot instruction class; mc_ctrl SHALL hold the FSM and output logic.

Verification
REQ-045 Scenario: addu (Op 0, Func 100001), zero-wait -> RegWr = 1, RegDst = 01, WDSel = 00 in cycle 4; instr_done in cycle 4.
REQ-046 Scenario: lw with dm_rdy delayed 3 cycles -> dm_req high for 4 cycles, dm_we = 0; WB asserts RegWr with WDSel = 01; total 8 cycles.
REQ-047 Scenario: beq with Zero = 1, then Zero = 0 -> PCWr = 1 with NPCSel = 01 in EXEC for the first, PCWr = 0 for the second; both retire in 3 cycles.
REQ-048 Scenario: jal -> in DECODE: PCWr = 1, NPCSel = 10, RegWr = 1, RegDst = 10, WDSel = 10; next cycle im_req = 1.
REQ-049 Scenario: Op = 111111 -> illegal pulses once, no write enables, return to FETCH.
REQ-050 Scenario: rst_n pulled low mid-MEM for sw -> dm_req and dm_we drop at once; no instr_done; after release, im_req = 1.
